// File: rtl/xor_stream_accum.sv
// Streaming XOR stage: pairwise a^b per beat, or XOR-fold of a whole frame into one result.
// Single registered output slot with a valid/ready handshake on both sides.
`timescale 1ns/1ps
module xor_stream_accum #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_acc, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_y;
    logic               r_out_parity;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_overflow;

    logic               w_accept;
    logic [WIDTH-1:0]   w_ab;
    logic [WIDTH-1:0]   w_fold;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_emit;
    logic [WIDTH-1:0]   w_emit_y;
    logic [CNT_W-1:0]   w_emit_cnt;
    logic               w_emit_ovf;

    // No skid buffer: a new beat is taken only if the output slot is free or retiring now.
    assign in_ready  = rst_n && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_ab      = in_a ^ in_b;
    assign w_fold    = r_acc ^ w_ab;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block is given a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_emit_y    = w_ab;
        w_emit_cnt  = CNT_W'(1);
        w_emit_ovf  = 1'b0;

        if (w_accept) begin
            unique case (r_state)
                IDLE: begin
                    if (!mode || in_last) begin
                        w_emit = 1'b1;
                    end else begin
                        w_acc_nxt   = w_ab;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    // Closing beat either by in_last or by hitting the frame length cap.
                    if (in_last || (w_cnt_inc == CNT_W'(MAX_LEN))) begin
                        w_emit      = 1'b1;
                        w_emit_y    = w_fold;
                        w_emit_cnt  = w_cnt_inc;
                        w_emit_ovf  = !in_last;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt = w_fold;
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: output data fields are reset too, so the interface reads all-zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_y        <= '0;
            r_out_parity   <= 1'b0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_emit) begin
            r_out_valid    <= 1'b1;
            r_out_y        <= w_emit_y;
            r_out_parity   <= ^w_emit_y;
            r_out_count    <= w_emit_cnt;
            r_out_overflow <= w_emit_ovf;
        end else if (out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_y        = r_out_y;
    assign out_parity   = r_out_parity;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_xor_stream_accum.sv
// Directed bench for xor_stream_accum (MAX_LEN=4): pairwise, fold, backpressure,
// length cap, mid-frame reset and mode change inside a frame.
`timescale 1ns/1ps
module tb_xor_stream_accum;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int n_checks = 0;
    int n_fails  = 0;

    xor_stream_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_parity   (out_parity),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one beat at a falling edge, hold it until accepted, drop in_valid #1 after the edge.
    task automatic send(input logic m, input logic [7:0] a, input logic [7:0] b, input logic last);
        int waited = 0;
        @(negedge clk);
        mode     = m;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] y, input logic [2:0] cnt, input logic ovf);
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_y"}, 32'(out_y), 32'(y));
        check({tag, "_parity"}, 32'(out_parity), 32'(^y));
        check({tag, "_count"}, 32'(out_count), 32'(cnt));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(ovf));
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_y", 32'(out_y), 32'h0);
        check("rst_count", 32'(out_count), 32'h0);
        check("rst_ovf", 32'(out_overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'h1);

        // 1: pairwise A5^0F = AA
        send(1'b0, 8'hA5, 8'h0F, 1'b0);
        check_out("pair", 8'hAA, 3'd1, 1'b0);

        // 2: fold 01^02^04^08^10^20 = 3F over three beats
        send(1'b1, 8'h01, 8'h02, 1'b0);
        check("acc_b1_valid", 32'(out_valid), 32'h0);
        send(1'b1, 8'h04, 8'h08, 1'b0);
        check("acc_b2_valid", 32'(out_valid), 32'h0);
        send(1'b1, 8'h10, 8'h20, 1'b1);
        check_out("acc", 8'h3F, 3'd3, 1'b0);

        // 3: hold for 5 cycles, then retire and load on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_valid", 32'(out_valid), 32'h1);
            check("bp_y", 32'(out_y), 32'h3F);
            check("bp_count", 32'(out_count), 32'h3);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(1'b0, 8'h12, 8'h34, 1'b0);
        check_out("bp_new", 8'h26, 3'd1, 1'b0);

        // 4: length cap at 4 beats, beat 5 opens a fresh frame
        send(1'b1, 8'h01, 8'h00, 1'b0);
        check("ovf_b1_valid", 32'(out_valid), 32'h0);
        send(1'b1, 8'h02, 8'h00, 1'b0);
        send(1'b1, 8'h03, 8'h00, 1'b0);
        check("ovf_b3_valid", 32'(out_valid), 32'h0);
        send(1'b1, 8'h04, 8'h00, 1'b0);
        check_out("ovf", 8'h04, 3'd4, 1'b1);
        send(1'b1, 8'h05, 8'h00, 1'b0);
        check("ovf_b5_valid", 32'(out_valid), 32'h0);
        send(1'b1, 8'h06, 8'h00, 1'b1);
        check_out("ovf_next", 8'h03, 3'd2, 1'b0);

        // 5: reset mid-frame drops the partial fold
        send(1'b1, 8'h11, 8'h00, 1'b0);
        send(1'b1, 8'h22, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b1, 8'hFF, 8'h00, 1'b1);
        check_out("midrst", 8'hFF, 3'd1, 1'b0);

        // 6: mode drops to 0 inside an open frame; frame still folds to 11^22^44 = 77
        send(1'b1, 8'h01, 8'h10, 1'b0);
        send(1'b0, 8'h02, 8'h20, 1'b0);
        check("mode_b2_valid", 32'(out_valid), 32'h0);
        send(1'b0, 8'h04, 8'h40, 1'b1);
        check_out("mode", 8'h77, 3'd3, 1'b0);

        // Drain
        @(posedge clk);
        #1;
        check("drain_valid", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
